// File: rtl/alarm_game_multi.sv
// alarm_game_multi: multi-alarm wake-up controller with snooze and a switch-matching
// minigame that must be won ROUNDS times in a row to dismiss the ringing alarm.
module alarm_game_multi #(
  parameter int NUM_ALARMS = 2,
  parameter int TIME_W     = 16,
  parameter int NUM_LEDS   = 10,
  parameter int ROUNDS     = 3,
  parameter int ROUND_CYC  = 1000,
  parameter int SNOOZE_CYC = 5000,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                         s2clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_ALARMS-1:0]        alarm_en,
  input  logic [TIME_W-1:0]            current,
  input  logic [NUM_ALARMS*TIME_W-1:0] alarm_times,
  input  logic                         push_m,
  input  logic                         push_snooze,
  input  logic [NUM_LEDS-1:0]          switches,
  output logic [2:0]                   state,
  output logic                         ringing,
  output logic [2:0]                   active_alarm,
  output logic [NUM_LEDS-1:0]          target_led,
  output logic [3:0]                   round_cnt,
  output logic [2:0]                   snooze_used,
  output logic                         done
);
  localparam int RW = $clog2(ROUND_CYC);
  localparam int SW = $clog2(SNOOZE_CYC);
  typedef enum logic [2:0] {IDLE = 3'b000, ARMED = 3'b001, RING = 3'b010, GAME = 3'b011, SNOOZE = 3'b100} st_t;
  st_t st, st_n;
  logic [NUM_ALARMS-1:0] fired, fired_n, same, eq, hit;
  logic [7:0] lfsr, lfsr_n, idx;
  logic [RW-1:0] rtmr, rtmr_n;
  logic [SW-1:0] stmr, stmr_n;
  logic [2:0] act_n, su_n, lo;
  logic [3:0] rc_n;
  logic [NUM_LEDS-1:0] tgt_n, cand, new_t;
  logic done_n;
  assign state   = st;
  assign ringing = st == RING;
  // Lowest-index pending alarm wins when several match at once
  always_comb begin
    lo = '0;
    for (int k = 0; k < NUM_ALARMS; k++) same[k] = current == alarm_times[k*TIME_W +: TIME_W];
    eq  = same & alarm_en;
    hit = eq & ~fired;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) if (hit[k]) lo = 3'(k);
  end
  // A fresh target may not repeat the one on display, so collisions rotate by one LED
  always_comb begin
    idx   = 8'(lfsr % 8'(NUM_LEDS));
    cand  = {{(NUM_LEDS-1){1'b0}}, 1'b1} << idx;
    new_t = cand == target_led ? {cand[NUM_LEDS-2:0], cand[NUM_LEDS-1]} : cand;
  end
  always_comb begin
    st_n    = st;
    lfsr_n  = st == IDLE ? lfsr : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    fired_n = (fired | (st != IDLE ? eq : '0)) & same;
    act_n   = active_alarm;
    su_n    = snooze_used;
    rc_n    = round_cnt;
    tgt_n   = target_led;
    rtmr_n  = rtmr;
    stmr_n  = stmr;
    done_n  = 1'b0;
    case (st)
      IDLE:  st_n = ARMED;
      ARMED: if (|hit) begin
        st_n  = RING;
        act_n = lo;
        su_n  = '0;
      end
      RING: if (push_m) begin
        st_n   = GAME;
        rc_n   = '0;
        rtmr_n = RW'(ROUND_CYC - 1);
        tgt_n  = new_t;
      end else if (push_snooze && 32'(snooze_used) < MAX_SNOOZE) begin
        st_n   = SNOOZE;
        su_n   = snooze_used + 3'd1;
        stmr_n = SW'(SNOOZE_CYC - 1);
      end
      SNOOZE: if (stmr == '0) st_n = RING;
        else stmr_n = stmr - 1'b1;
      GAME: if (switches == target_led) begin
        rtmr_n = RW'(ROUND_CYC - 1);
        if (round_cnt == 4'(ROUNDS - 1)) begin
          st_n   = ARMED;
          done_n = 1'b1;
          tgt_n  = '0;
          rc_n   = '0;
        end else begin
          rc_n  = round_cnt + 4'd1;
          tgt_n = new_t;
        end
      end else if (|(switches & ~target_led)) begin
        rc_n   = '0;
        rtmr_n = RW'(ROUND_CYC - 1);
      end else if (rtmr == '0) begin
        rc_n   = '0;
        tgt_n  = new_t;
        rtmr_n = RW'(ROUND_CYC - 1);
      end else rtmr_n = rtmr - 1'b1;
      default: st_n = ARMED;
    endcase
    if (!enable) begin
      st_n    = IDLE;
      lfsr_n  = 8'h5A;
      fired_n = '0;
      act_n   = '0;
      su_n    = '0;
      rc_n    = '0;
      tgt_n   = '0;
      rtmr_n  = '0;
      stmr_n  = '0;
      done_n  = 1'b0;
    end
  end
  always_ff @(posedge s2clk or posedge reset)
    if (reset) begin
      st           <= IDLE;
      lfsr         <= 8'h5A;
      fired        <= '0;
      active_alarm <= '0;
      snooze_used  <= '0;
      round_cnt    <= '0;
      target_led   <= '0;
      rtmr         <= '0;
      stmr         <= '0;
      done         <= 1'b0;
    end else begin
      st           <= st_n;
      lfsr         <= lfsr_n;
      fired        <= fired_n;
      active_alarm <= act_n;
      snooze_used  <= su_n;
      round_cnt    <= rc_n;
      target_led   <= tgt_n;
      rtmr         <= rtmr_n;
      stmr         <= stmr_n;
      done         <= done_n;
    end
endmodule
